// File: rtl/gbf_loader.sv
// Fill engine for one double-buffered GBF pair: writes a valid/ready line stream
// into bank 1 or bank 2, serving the controller's need_data requests in ping-pong order.
module gbf_loader #(
    parameter int GBF_DATA_BITWIDTH = 256,
    parameter int GBF_ADDR_BITWIDTH = 5,
    parameter int GBF_DEPTH         = 32,
    parameter int TILE_CNT_BITWIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [GBF_ADDR_BITWIDTH:0]   cfg_fill_len,
    input  logic [TILE_CNT_BITWIDTH-1:0] cfg_num_tiles,
    input  logic                         need_data1,
    input  logic                         need_data2,
    input  logic                         s_valid,
    input  logic [GBF_DATA_BITWIDTH-1:0] s_data,
    output logic                         s_ready,
    output logic                         en1a,
    output logic                         we1a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
    output logic                         en2a,
    output logic                         we2a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
    output logic                         buf1_ready,
    output logic                         buf2_ready,
    output logic                         data_avail,
    output logic                         busy,
    output logic                         finish
);
    localparam int LW = GBF_ADDR_BITWIDTH + 1;

    typedef enum logic [2:0] {IDLE, ARB, FILL1, FILL2, DONE} state_t;

    state_t                       state_q;
    logic [LW-1:0]                fill_len_q;
    logic [TILE_CNT_BITWIDTH-1:0] num_tiles_q;
    logic [TILE_CNT_BITWIDTH-1:0] tiles_started_q;
    logic [GBF_ADDR_BITWIDTH-1:0] line_cnt_q;
    logic                         need1_q, need2_q, pend1_q, pend2_q;
    logic                         last_bank_q;   // 1 means bank 2 was filled last
    logic                         en1_q, we1_q, en2_q, we2_q;
    logic [GBF_ADDR_BITWIDTH-1:0] addr1_q, addr2_q;
    logic [GBF_DATA_BITWIDTH-1:0] wdata1_q, wdata2_q;
    logic                         buf1_ready_q, buf2_ready_q, busy_q, finish_q;

    logic                         rise1_d, rise2_d, last_beat_d;
    logic [GBF_ADDR_BITWIDTH-1:0] line_cnt_d;
    logic [TILE_CNT_BITWIDTH-1:0] tiles_started_d;
    logic [LW-1:0]                fill_len_d;

    assign rise1_d         = need_data1 & ~need1_q;
    assign rise2_d         = need_data2 & ~need2_q;
    assign line_cnt_d      = line_cnt_q + GBF_ADDR_BITWIDTH'(1);
    assign tiles_started_d = tiles_started_q + TILE_CNT_BITWIDTH'(1);
    assign last_beat_d     = ({1'b0, line_cnt_q} == (fill_len_q - LW'(1)));
    assign fill_len_d      = (cfg_fill_len == '0 || cfg_fill_len > LW'(GBF_DEPTH))
                             ? LW'(GBF_DEPTH) : cfg_fill_len;

    assign s_ready    = (state_q == FILL1) || (state_q == FILL2);
    assign en1a       = en1_q;
    assign we1a       = we1_q;
    assign addr1a     = addr1_q;
    assign w_data1a   = wdata1_q;
    assign en2a       = en2_q;
    assign we2a       = we2_q;
    assign addr2a     = addr2_q;
    assign w_data2a   = wdata2_q;
    assign buf1_ready = buf1_ready_q;
    assign buf2_ready = buf2_ready_q;
    assign busy       = busy_q;
    assign finish     = finish_q;
    assign data_avail = busy_q && (tiles_started_q < num_tiles_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            fill_len_q      <= '0;
            num_tiles_q     <= '0;
            tiles_started_q <= '0;
            line_cnt_q      <= '0;
            need1_q         <= 1'b0;
            need2_q         <= 1'b0;
            pend1_q         <= 1'b0;
            pend2_q         <= 1'b0;
            last_bank_q     <= 1'b1;
            en1_q           <= 1'b0;
            we1_q           <= 1'b0;
            en2_q           <= 1'b0;
            we2_q           <= 1'b0;
            addr1_q         <= '0;
            addr2_q         <= '0;
            wdata1_q        <= '0;
            wdata2_q        <= '0;
            buf1_ready_q    <= 1'b0;
            buf2_ready_q    <= 1'b0;
            busy_q          <= 1'b0;
            finish_q        <= 1'b0;
        end else begin
            need1_q <= need_data1;
            need2_q <= need_data2;
            en1_q   <= 1'b0;
            we1_q   <= 1'b0;
            en2_q   <= 1'b0;
            we2_q   <= 1'b0;
            // A new request means the controller consumed the bank; a final write below overrides.
            if (rise1_d) buf1_ready_q <= 1'b0;
            if (rise2_d) buf2_ready_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        fill_len_q      <= fill_len_d;
                        num_tiles_q     <= cfg_num_tiles;
                        tiles_started_q <= '0;
                        busy_q          <= 1'b1;
                        finish_q        <= 1'b0;
                        state_q         <= ARB;
                    end
                end
                ARB: begin
                    if (tiles_started_q == num_tiles_q) begin
                        busy_q   <= 1'b0;
                        finish_q <= 1'b1;
                        state_q  <= DONE;
                    end else if (pend1_q && (!pend2_q || last_bank_q)) begin
                        tiles_started_q <= tiles_started_d;
                        line_cnt_q      <= '0;
                        buf1_ready_q    <= 1'b0;
                        pend1_q         <= 1'b0;
                        state_q         <= FILL1;
                    end else if (pend2_q) begin
                        tiles_started_q <= tiles_started_d;
                        line_cnt_q      <= '0;
                        buf2_ready_q    <= 1'b0;
                        pend2_q         <= 1'b0;
                        state_q         <= FILL2;
                    end
                end
                FILL1: begin
                    if (s_valid) begin
                        en1_q      <= 1'b1;
                        we1_q      <= 1'b1;
                        addr1_q    <= line_cnt_q;
                        wdata1_q   <= s_data;
                        line_cnt_q <= line_cnt_d;
                        if (last_beat_d) begin
                            last_bank_q  <= 1'b0;
                            buf1_ready_q <= 1'b1;
                            state_q      <= ARB;
                        end
                    end
                end
                FILL2: begin
                    if (s_valid) begin
                        en2_q      <= 1'b1;
                        we2_q      <= 1'b1;
                        addr2_q    <= line_cnt_q;
                        wdata2_q   <= s_data;
                        line_cnt_q <= line_cnt_d;
                        if (last_beat_d) begin
                            last_bank_q  <= 1'b1;
                            buf2_ready_q <= 1'b1;
                            state_q      <= ARB;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // Placed after the FSM so a request arriving as a fill starts is not lost.
            if (rise1_d) pend1_q <= 1'b1;
            if (rise2_d) pend2_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gbf_loader.sv
// Directed bench for gbf_loader: ping-pong fills, stalls, arbitration, refill,
// length clamping, empty jobs and mid-fill reset.
module tb_gbf_loader;
    localparam int DW = 256;
    localparam int AW = 5;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   cfg_fill_len;
    logic [TW-1:0] cfg_num_tiles;
    logic          need_data1, need_data2;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          en1a, we1a, en2a, we2a;
    logic [AW-1:0] addr1a, addr2a;
    logic [DW-1:0] w_data1a, w_data2a;
    logic          buf1_ready, buf2_ready, data_avail, busy, finish;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gbf_loader #(
        .GBF_DATA_BITWIDTH(DW),
        .GBF_ADDR_BITWIDTH(AW),
        .GBF_DEPTH(32),
        .TILE_CNT_BITWIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_fill_len(cfg_fill_len), .cfg_num_tiles(cfg_num_tiles),
        .need_data1(need_data1), .need_data2(need_data2),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .en1a(en1a), .we1a(we1a), .addr1a(addr1a), .w_data1a(w_data1a),
        .en2a(en2a), .we2a(we2a), .addr2a(addr2a), .w_data2a(w_data2a),
        .buf1_ready(buf1_ready), .buf2_ready(buf2_ready),
        .data_avail(data_avail), .busy(busy), .finish(finish)
    );

    function automatic logic [DW-1:0] beat(input int n);
        return {8{32'hC0DE_0000 + 32'(n)}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; cfg_fill_len = '0; cfg_num_tiles = '0;
        need_data1 = 1'b0; need_data2 = 1'b0; s_valid = 1'b1; s_data = beat(99);
        step(); step();
        checks++; if ({s_ready, en1a, we1a, en2a, we2a, buf1_ready, buf2_ready, data_avail, busy, finish} !== 10'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0", {s_ready, en1a, we1a, en2a, we2a, buf1_ready, buf2_ready, data_avail, busy, finish}); end
        checks++; if ({addr1a, addr2a} !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", {addr1a, addr2a}); end
        checks++; if ((w_data1a | w_data2a) !== '0) begin errors++; $display("FAIL reset_data: got nonzero expected 0"); end
        $display("test_reset: done");
    endtask

    // need_data high across reset release; finish lands 11 edges after the start edge.
    task automatic test_ping_pong();
        logic exp_en1, exp_en2;
        need_data1 = 1'b1; need_data2 = 1'b1;
        step(); reset = 1'b1;
        step(); step();
        cfg_fill_len = 6'd4; cfg_num_tiles = 16'd2; s_valid = 1'b1; s_data = beat(0); start = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            step();
            start = 1'b0;
            s_data = beat(t);
            exp_en1 = (t >= 3 && t <= 6);
            exp_en2 = (t >= 8 && t <= 11);
            checks++; if (en1a !== exp_en1 || we1a !== exp_en1) begin errors++; $display("FAIL pp_en1 t=%0d: got %b/%b expected %b", t, en1a, we1a, exp_en1); end
            checks++; if (en2a !== exp_en2 || we2a !== exp_en2) begin errors++; $display("FAIL pp_en2 t=%0d: got %b/%b expected %b", t, en2a, we2a, exp_en2); end
            if (exp_en1) begin
                checks++; if (addr1a !== AW'(t - 3) || w_data1a !== beat(t - 1)) begin errors++; $display("FAIL pp_wr1 t=%0d: got addr %0d expected %0d", t, addr1a, t - 3); end
            end
            if (exp_en2) begin
                checks++; if (addr2a !== AW'(t - 8) || w_data2a !== beat(t - 1)) begin errors++; $display("FAIL pp_wr2 t=%0d: got addr %0d expected %0d", t, addr2a, t - 8); end
            end
            checks++; if (buf1_ready !== (t >= 6) || buf2_ready !== (t >= 11)) begin errors++; $display("FAIL pp_bufrdy t=%0d: got %b%b expected %b%b", t, buf1_ready, buf2_ready, t >= 6, t >= 11); end
            checks++; if (finish !== (t == 12) || busy !== (t <= 11)) begin errors++; $display("FAIL pp_finish t=%0d: got fin=%b busy=%b", t, finish, busy); end
            checks++; if (data_avail !== (t <= 6)) begin errors++; $display("FAIL pp_avail t=%0d: got %b expected %b", t, data_avail, t <= 6); end
        end
        step();
        checks++; if (finish !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL pp_hold: got fin=%b busy=%b expected 1/0", finish, busy); end
        $display("test_ping_pong: done");
    endtask

    task automatic test_stall();
        s_valid = 1'b0; need_data1 = 1'b0; step();
        need_data1 = 1'b1; step();
        checks++; if (buf1_ready !== 1'b0) begin errors++; $display("FAIL stall_bufdrop: got %b expected 0", buf1_ready); end
        start = 1'b1; cfg_fill_len = 6'd4; cfg_num_tiles = 16'd1;
        step(); start = 1'b0;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_arb: got %b expected 0", s_ready); end
        step();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_fill: got %b expected 1", s_ready); end
        for (int k = 0; k < 8; k++) begin
            s_valid = (k % 2 == 0);
            s_data = beat(100 + k);
            step();
            checks++; if (en1a !== (k % 2 == 0) || en2a !== 1'b0) begin errors++; $display("FAIL stall_en k=%0d: got en1=%b en2=%b", k, en1a, en2a); end
            checks++; if (addr1a !== AW'(k / 2)) begin errors++; $display("FAIL stall_addr k=%0d: got %0d expected %0d", k, addr1a, k / 2); end
            if (k % 2 == 0) begin
                checks++; if (w_data1a !== beat(100 + k)) begin errors++; $display("FAIL stall_data k=%0d: got %h", k, w_data1a[31:0]); end
            end
            checks++; if (buf1_ready !== (k >= 6)) begin errors++; $display("FAIL stall_bufrdy k=%0d: got %b", k, buf1_ready); end
        end
        checks++; if (finish !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL stall_finish: got fin=%b rdy=%b expected 1/0", finish, s_ready); end
        s_valid = 1'b1; step();
        checks++; if (s_ready !== 1'b0 || en1a !== 1'b0 || en2a !== 1'b0) begin errors++; $display("FAIL idle_noaccept: got rdy=%b en1=%b en2=%b", s_ready, en1a, en2a); end
        $display("test_stall: done");
    endtask

    // last_bank is bank 1 here, so with both pending bank 2 goes first; mid-job start is ignored.
    task automatic test_priority();
        s_valid = 1'b0; need_data1 = 1'b0; need_data2 = 1'b0; step();
        need_data1 = 1'b1; need_data2 = 1'b1; step();
        start = 1'b1; cfg_fill_len = 6'd2; cfg_num_tiles = 16'd2; s_valid = 1'b1; s_data = beat(200);
        for (int t = 1; t <= 8; t++) begin
            step();
            start = (t == 3);
            if (t == 3) begin cfg_fill_len = 6'd1; cfg_num_tiles = 16'd5; end
            s_data = beat(200 + t);
            checks++; if (en2a !== (t == 3 || t == 4) || en1a !== (t == 6 || t == 7)) begin errors++; $display("FAIL prio_en t=%0d: got en1=%b en2=%b", t, en1a, en2a); end
            if (t == 3 || t == 4) begin
                checks++; if (addr2a !== AW'(t - 3) || w_data2a !== beat(199 + t)) begin errors++; $display("FAIL prio_wr2 t=%0d: got addr %0d expected %0d", t, addr2a, t - 3); end
            end
            if (t == 6 || t == 7) begin
                checks++; if (addr1a !== AW'(t - 6) || w_data1a !== beat(199 + t)) begin errors++; $display("FAIL prio_wr1 t=%0d: got addr %0d expected %0d", t, addr1a, t - 6); end
            end
            checks++; if (buf2_ready !== (t >= 4) || buf1_ready !== (t >= 7)) begin errors++; $display("FAIL prio_bufrdy t=%0d: got %b%b", t, buf1_ready, buf2_ready); end
            checks++; if (finish !== (t == 8)) begin errors++; $display("FAIL prio_finish t=%0d: got %b expected %b", t, finish, t == 8); end
        end
        start = 1'b0; step();
        $display("test_priority: done");
    endtask

    task automatic test_refill();
        start = 1'b1; cfg_fill_len = 6'd1; cfg_num_tiles = 16'd2; s_valid = 1'b1; s_data = beat(300);
        step(); start = 1'b0;
        step();
        checks++; if (s_ready !== 1'b0 || data_avail !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL refill_wait: got rdy=%b avail=%b busy=%b", s_ready, data_avail, busy); end
        need_data1 = 1'b0; step();
        need_data1 = 1'b1; step();
        checks++; if (buf1_ready !== 1'b0 || buf2_ready !== 1'b1) begin errors++; $display("FAIL refill_drop1: got %b%b expected 01", buf1_ready, buf2_ready); end
        step();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL refill_fill1: got %b expected 1", s_ready); end
        step();
        checks++; if (en1a !== 1'b1 || addr1a !== 5'd0 || buf1_ready !== 1'b1 || en2a !== 1'b0) begin errors++; $display("FAIL refill_wr1: got en=%b addr=%0d rdy=%b", en1a, addr1a, buf1_ready); end
        need_data1 = 1'b0; step();
        checks++; if (data_avail !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL refill_avail: got avail=%b rdy=%b expected 1/0", data_avail, s_ready); end
        need_data1 = 1'b1; step();
        checks++; if (buf1_ready !== 1'b0) begin errors++; $display("FAIL refill_drop2: got %b expected 0", buf1_ready); end
        step(); step();
        checks++; if (en1a !== 1'b1 || addr1a !== 5'd0 || buf1_ready !== 1'b1 || data_avail !== 1'b0) begin errors++; $display("FAIL refill_wr2: got en=%b addr=%0d rdy=%b avail=%b", en1a, addr1a, buf1_ready, data_avail); end
        step();
        checks++; if (finish !== 1'b1 || busy !== 1'b0 || buf2_ready !== 1'b1) begin errors++; $display("FAIL refill_finish: got fin=%b busy=%b b2=%b", finish, busy, buf2_ready); end
        step();
        $display("test_refill: done");
    endtask

    task automatic test_clamp();
        need_data2 = 1'b0; step();
        need_data2 = 1'b1; step();
        start = 1'b1; cfg_fill_len = 6'd0; cfg_num_tiles = 16'd1; s_valid = 1'b1; s_data = beat(400);
        step(); start = 1'b0;
        step();
        for (int i = 0; i < 32; i++) begin
            s_data = beat(400 + i);
            step();
            checks++; if (en2a !== 1'b1 || en1a !== 1'b0 || addr2a !== AW'(i) || w_data2a !== beat(400 + i)) begin errors++; $display("FAIL clamp_wr i=%0d: got en2=%b addr=%0d", i, en2a, addr2a); end
            checks++; if (buf2_ready !== (i == 31)) begin errors++; $display("FAIL clamp_bufrdy i=%0d: got %b", i, buf2_ready); end
        end
        step();
        checks++; if (en2a !== 1'b0) begin errors++; $display("FAIL clamp_stop: got en2=%b expected 0", en2a); end
        step();
        checks++; if (finish !== 1'b1) begin errors++; $display("FAIL clamp_finish: got %b expected 1", finish); end
        step();
        start = 1'b1; cfg_fill_len = 6'd4; cfg_num_tiles = 16'd0;
        step(); start = 1'b0;
        checks++; if (finish !== 1'b0 || busy !== 1'b1 || data_avail !== 1'b0) begin errors++; $display("FAIL zero_tiles_t1: got fin=%b busy=%b avail=%b", finish, busy, data_avail); end
        step();
        checks++; if (finish !== 1'b1 || busy !== 1'b0 || en1a !== 1'b0 || en2a !== 1'b0) begin errors++; $display("FAIL zero_tiles_t2: got fin=%b busy=%b en=%b%b", finish, busy, en1a, en2a); end
        step();
        $display("test_clamp: done");
    endtask

    task automatic test_reset_mid();
        bit seen;
        need_data1 = 1'b0; step();
        need_data1 = 1'b1; step();
        start = 1'b1; cfg_fill_len = 6'd4; cfg_num_tiles = 16'd1; s_valid = 1'b1; s_data = beat(500);
        step(); start = 1'b0;
        step(); step(); step(); step();
        checks++; if (en1a !== 1'b1 || addr1a !== 5'd2) begin errors++; $display("FAIL mid_line2: got en=%b addr=%0d expected 1/2", en1a, addr1a); end
        reset = 1'b0; #1;
        checks++; if ({s_ready, en1a, we1a, en2a, buf1_ready, buf2_ready, data_avail, busy, finish} !== 9'b0 || addr1a !== '0 || w_data1a !== '0) begin
            errors++; $display("FAIL mid_reset: got ctrl=%b addr=%0d", {s_ready, en1a, we1a, en2a, buf1_ready, buf2_ready, data_avail, busy, finish}, addr1a); end
        step(); reset = 1'b1;
        step();
        start = 1'b1; s_data = beat(600);
        step(); start = 1'b0;
        step(); step();
        checks++; if (en1a !== 1'b1 || addr1a !== 5'd0 || w_data1a !== beat(600)) begin errors++; $display("FAIL mid_restart: got en=%b addr=%0d expected 1/0", en1a, addr1a); end
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (finish === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_complete: finish not seen within 20 cycles"); end
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_ping_pong();
        test_stall();
        test_priority();
        test_refill();
        test_clamp();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
